// File: rtl/i2c_target.sv
// I2C target with a single 7-bit address: byte-level write strobes and read requests,
// repeated START support, open-drain SDA via sda_oe. SCL/SDA are oversampled on clk.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       addressed,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_ADDR,
        S_WR_DATA,
        S_ACK_WR,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    // Synchronisers reset to the idle bus level so reset release creates no edges
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_hist;
    logic                   r_sda_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
            r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    // SCL must be high in both samples so an SCL edge is never mistaken for START/STOP
    assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_rw;
    logic       r_byte_done;
    logic       r_sda_oe;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_addressed;
    logic       r_busy;

    state_t     w_state_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [7:0] w_shift_nxt;
    logic       w_rw_nxt;
    logic       w_byte_done_nxt;
    logic       w_sda_oe_nxt;
    logic [7:0] w_rx_data_nxt;
    logic       w_rx_valid_nxt;
    logic       w_addressed_nxt;
    logic       w_busy_nxt;
    logic       w_tx_req;
    logic [7:0] w_shift_in;

    assign w_shift_in = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'd0;
            r_rw        <= 1'b0;
            r_byte_done <= 1'b0;
            r_sda_oe    <= 1'b0;
            r_rx_data   <= 8'd0;
            r_rx_valid  <= 1'b0;
            r_addressed <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rw        <= w_rw_nxt;
            r_byte_done <= w_byte_done_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_rx_data   <= w_rx_data_nxt;
            r_rx_valid  <= w_rx_valid_nxt;
            r_addressed <= w_addressed_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // r_byte_done marks "8th bit sampled, waiting for the SCL fall that opens the ACK slot"
    // (in RD_ACK it marks "master ACK sampled, waiting for the fall to reload").
    always_comb begin
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_rw_nxt        = r_rw;
        w_byte_done_nxt = r_byte_done;
        w_sda_oe_nxt    = r_sda_oe;
        w_rx_data_nxt   = r_rx_data;
        w_rx_valid_nxt  = 1'b0;
        w_addressed_nxt = r_addressed;
        w_busy_nxt      = r_busy;
        w_tx_req        = 1'b0;

        if (w_start) begin
            w_state_nxt     = S_ADDR;
            w_bit_cnt_nxt   = 3'd0;
            w_byte_done_nxt = 1'b0;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b1;
            w_addressed_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt     = S_IDLE;
            w_bit_cnt_nxt   = 3'd0;
            w_byte_done_nxt = 1'b0;
            w_sda_oe_nxt    = 1'b0;
            w_busy_nxt      = 1'b0;
            w_addressed_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                end
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) w_byte_done_nxt = 1'b1;
                    end else if (w_scl_fall && r_byte_done) begin
                        w_byte_done_nxt = 1'b0;
                        if (r_shift[7:1] == ADDR) begin
                            w_state_nxt     = S_ACK_ADDR;
                            w_sda_oe_nxt    = 1'b1;
                            w_addressed_nxt = 1'b1;
                            w_rw_nxt        = r_shift[0];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                S_ACK_ADDR: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = 3'd0;
                        if (r_rw) begin
                            w_state_nxt  = S_RD_DATA;
                            w_tx_req     = 1'b1;
                            w_shift_nxt  = tx_data;
                            w_sda_oe_nxt = ~tx_data[7];
                        end else begin
                            w_state_nxt  = S_WR_DATA;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_shift_in;
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_byte_done_nxt = 1'b1;
                            w_rx_data_nxt   = w_shift_in;
                            w_rx_valid_nxt  = 1'b1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_state_nxt     = S_ACK_WR;
                        w_sda_oe_nxt    = 1'b1;
                        w_byte_done_nxt = 1'b0;
                    end
                end
                S_ACK_WR: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = S_WR_DATA;
                        w_sda_oe_nxt  = 1'b0;
                        w_bit_cnt_nxt = 3'd0;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_fall) begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt     = S_RD_ACK;
                            w_sda_oe_nxt    = 1'b0;
                            w_byte_done_nxt = 1'b0;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_state_nxt  = S_IGNORE;
                            w_sda_oe_nxt = 1'b0;
                        end else begin
                            w_byte_done_nxt = 1'b1;
                        end
                    end else if (w_scl_fall && r_byte_done) begin
                        w_state_nxt     = S_RD_DATA;
                        w_byte_done_nxt = 1'b0;
                        w_tx_req        = 1'b1;
                        w_shift_nxt     = tx_data;
                        w_sda_oe_nxt    = ~tx_data[7];
                        w_bit_cnt_nxt   = 3'd0;
                    end
                end
                S_IGNORE: begin
                    w_sda_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt  = S_IDLE;
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe    = r_sda_oe;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign tx_req    = w_tx_req;
    assign addressed = r_addressed;
    assign busy      = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: an I2C master model drives the bus; a transaction-level model
// predicts ACKs, received bytes, read data and tx_req counts.
module tb_i2c_target;

    localparam logic [6:0] ADDR = 7'h42;
    localparam int         Q    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl;
    logic       m_pull;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_req;
    logic [7:0] tx_data;
    logic       addressed;
    logic       busy;

    logic [7:0] tx_bytes [8];
    logic [7:0] rx_q [$];
    logic [7:0] exp_rx [$];
    int n_txreq  = 0;
    int n_overlap = 0;
    int n_oe     = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign sda_line = ~(m_pull | sda_oe);
    assign tx_data  = tx_bytes[n_txreq % 8];

    i2c_target #(.ADDR(ADDR), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .addressed (addressed),
        .busy      (busy)
    );

    always @(posedge clk) if (tx_req === 1'b1) n_txreq <= n_txreq + 1;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rx_q.push_back(rx_data);
        if (rx_valid === 1'b1 && tx_req === 1'b1) n_overlap = n_overlap + 1;
        if (sda_oe === 1'b1) n_oe = n_oe + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_bit(input logic wb, output logic rb);
        wait_clk(Q);
        m_pull = ~wb;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        rb = sda_line;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_start();
        wait_clk(Q);
        m_pull = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_rstart();
        wait_clk(Q);
        m_pull = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_pull = 1'b1;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q);
        m_pull = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        m_pull = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], dummy);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic master_ack, output logic [7:0] b);
        logic dummy;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, b[i]);
        bus_bit(~master_ack, dummy);
    endtask

    task automatic check_rx(input string tag);
        chk({tag, "_rxcnt"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            chk({tag, "_rxdata"}, 32'(rx_q[i]), 32'(exp_rx[i]));
    endtask

    // Write transaction: the target ACKs every byte iff the address matches, and each
    // data byte written then appears once on rx_data.
    task automatic write_txn(input logic [6:0] a, input int n, input logic [7:0] first,
                             input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] d;
        int         oe_before;
        hit = (a == ADDR);
        oe_before = n_oe;
        bus_start();
        chk({tag, "_busy"}, 32'(busy), 32'(1));
        send_byte({a, 1'b0}, ack);
        chk({tag, "_aack"}, 32'(ack), hit ? 32'(0) : 32'(1));
        wait_clk(Q);
        chk({tag, "_addressed"}, 32'(addressed), 32'(hit));
        for (int i = 0; i < n; i++) begin
            d = (i == 0) ? first : 8'($urandom);
            send_byte(d, ack);
            chk({tag, "_dack"}, 32'(ack), hit ? 32'(0) : 32'(1));
            if (hit) exp_rx.push_back(d);
        end
        bus_stop();
        chk({tag, "_busy_end"}, 32'(busy), 32'(0));
        chk({tag, "_addr_end"}, 32'(addressed), 32'(0));
        if (!hit) chk({tag, "_oe_never"}, 32'(n_oe - oe_before), 32'(0));
        check_rx(tag);
    endtask

    // Read transaction: master ACKs all but the last byte; the target requests one byte
    // per ACKed slot plus the first, and returns them MSB first.
    task automatic read_txn(input logic [6:0] a, input int n, input logic [7:0] first,
                            input string tag);
        logic       ack;
        logic       hit;
        logic [7:0] b;
        logic [7:0] exp_b [4];
        int         base;
        hit  = (a == ADDR);
        base = n_txreq;
        for (int i = 0; i < n; i++) begin
            exp_b[i] = (i == 0) ? first : 8'($urandom);
            tx_bytes[(base + i) % 8] = exp_b[i];
        end
        bus_start();
        send_byte({a, 1'b1}, ack);
        chk({tag, "_aack"}, 32'(ack), hit ? 32'(0) : 32'(1));
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, b);
            chk({tag, "_rdata"}, 32'(b), hit ? 32'(exp_b[i]) : 32'(8'hFF));
        end
        bus_stop();
        chk({tag, "_txreq"}, 32'(n_txreq - base), hit ? 32'(n) : 32'(0));
        chk({tag, "_busy_end"}, 32'(busy), 32'(0));
        check_rx(tag);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic       dummy;
        logic [7:0] b;
        logic [6:0] a;
        int         txb;
        rst    = 1'b1;
        scl    = 1'b1;
        m_pull = 1'b0;
        for (int i = 0; i < 8; i++) tx_bytes[i] = 8'h00;
        wait_clk(4);
        chk("rst_sda_oe", 32'(sda_oe), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_addressed", 32'(addressed), 32'(0));
        chk("rst_rx_valid", 32'(rx_valid), 32'(0));
        chk("rst_tx_req", 32'(tx_req), 32'(0));
        chk("rst_rx_data", 32'(rx_data), 32'(0));
        rst = 1'b0;
        wait_clk(4);

        write_txn(ADDR, 1, 8'hA5, "t1");
        write_txn(7'h43, 1, 8'h11, "t2");
        read_txn(ADDR, 2, 8'h3C, "t3");

        // Repeated START after half a write byte, then a read
        txb = n_txreq;
        tx_bytes[n_txreq % 8] = 8'h5A;
        bus_start();
        send_byte(8'h84, ack);
        chk("t4_aack_w", 32'(ack), 32'(0));
        for (int i = 0; i < 4; i++) bus_bit(1'($urandom), dummy);
        bus_rstart();
        send_byte(8'h85, ack);
        chk("t4_aack_r", 32'(ack), 32'(0));
        read_byte(1'b0, b);
        chk("t4_rdata", 32'(b), 32'(8'h5A));
        bus_stop();
        chk("t4_txreq", 32'(n_txreq - txb), 32'(1));
        check_rx("t4");

        // Asynchronous reset while the target holds the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(b[0] | 1'b1 ? 1'(8'h84 >> i) : 1'b0, dummy);
        for (int k = 0; k < 20 && sda_oe !== 1'b1; k++) wait_clk(1);
        chk("t5_oe_before", 32'(sda_oe), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t5_oe_rst", 32'(sda_oe), 32'(0));
        chk("t5_busy_rst", 32'(busy), 32'(0));
        chk("t5_addr_rst", 32'(addressed), 32'(0));
        chk("t5_rxv_rst", 32'(rx_valid), 32'(0));
        chk("t5_txr_rst", 32'(tx_req), 32'(0));
        scl    = 1'b1;
        m_pull = 1'b0;
        wait_clk(4);
        rst = 1'b0;
        wait_clk(4);
        write_txn(ADDR, 1, 8'($urandom), "t5b");

        // STOP three bits into a data byte
        bus_start();
        send_byte(8'h84, ack);
        chk("t6_aack", 32'(ack), 32'(0));
        for (int i = 0; i < 3; i++) bus_bit(1'($urandom), dummy);
        bus_stop();
        chk("t6_busy", 32'(busy), 32'(0));
        chk("t6_addr", 32'(addressed), 32'(0));
        check_rx("t6");

        for (int t = 0; t < 10; t++) begin
            if ($urandom % 2 == 0) a = ADDR;
            else begin
                a = 7'($urandom);
                if (a == ADDR) a = a ^ 7'h01;
            end
            if ($urandom % 2 == 0) write_txn(a, 1 + int'($urandom % 3), 8'($urandom), "rw");
            else read_txn(a, 1 + int'($urandom % 3), 8'($urandom), "rr");
        end

        chk("pulse_overlap", 32'(n_overlap), 32'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
